// File: rtl/voice_mix_sequencer_pkg.sv
// Shared constants for the voice mixer: FSM encoding and the offset-binary midpoint.
package voice_mix_sequencer_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      REDUCE = 1'b1
   } state_t;

   // Silence level for an unsigned offset-binary sample of the given width.
   function automatic int unsigned mid_value(input int unsigned bits);
      return 32'd1 << (bits - 1);
   endfunction

endpackage

// File: rtl/voice_mix_sequencer_mixer.sv
// Averages two offset-binary samples; purely combinational, result always fits DATA_BITS.
module two_into_one_mixer #(
   parameter int DATA_BITS = 12
) (
   input  logic [DATA_BITS-1:0] a,
   input  logic [DATA_BITS-1:0] b,
   output logic [DATA_BITS-1:0] dout
);

   logic [DATA_BITS:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign dout = sum[DATA_BITS:1];

endmodule

// File: rtl/voice_mix_sequencer.sv
// Folds NUM_VOICES latched samples through one shared mixer, one pairwise mix per clock.
// Result appears NUM_VOICES-1 clocks after the accepting strobe; strobes while busy are dropped and flagged.
module voice_mix_sequencer
   import voice_mix_sequencer_pkg::*;
#(
   parameter int DATA_BITS   = 12,
   parameter int NUM_VOICES  = 4,
   parameter int LOG2_VOICES = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            sample_strobe,
   input  logic [NUM_VOICES*DATA_BITS-1:0] voices_in,
   input  logic [NUM_VOICES-1:0]           voice_mask,
   output logic [DATA_BITS-1:0]            dout,
   output logic                            dout_valid,
   output logic                            busy,
   output logic                            overrun
);

   localparam int CW = (LOG2_VOICES < 1) ? 1 : LOG2_VOICES;
   localparam logic [DATA_BITS-1:0] MID = DATA_BITS'(mid_value(DATA_BITS));

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] vbuf [NUM_VOICES];
   logic [CW-1:0]        level_q, pair_q;
   logic [CW-1:0]        idx_a, idx_b, last_pair;
   logic [DATA_BITS-1:0] mix_a, mix_b, mix_y;
   logic                 accept, final_mix;

   // Base is aligned to 2*stride, so OR-ing the stride in is the same as adding it.
   always_comb begin
      idx_a     = pair_q << (level_q + 1'b1);
      idx_b     = idx_a | (CW'(1) << level_q);
      last_pair = CW'((NUM_VOICES >> (level_q + 1'b1)) - 1);
      final_mix = (level_q == CW'(LOG2_VOICES - 1)) && (pair_q == '0);
      mix_a     = vbuf[idx_a];
      mix_b     = vbuf[idx_b];
   end

   two_into_one_mixer #(.DATA_BITS(DATA_BITS)) u_mixer (
      .a    (mix_a),
      .b    (mix_b),
      .dout (mix_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sample_strobe) state_d = REDUCE;
         REDUCE:  if (final_mix)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept = (state_q == IDLE) && sample_strobe;
      busy   = (state_q == REDUCE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) vbuf[i] <= '0;
         level_q    <= '0;
         pair_q     <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         overrun    <= sample_strobe && (state_q == REDUCE);
         if (accept) begin
            for (int i = 0; i < NUM_VOICES; i++)
               vbuf[i] <= voice_mask[i] ? voices_in[i*DATA_BITS +: DATA_BITS] : MID;
            level_q <= '0;
            pair_q  <= '0;
         end else if (state_q == REDUCE) begin
            vbuf[idx_a] <= mix_y;
            if (final_mix) begin
               dout       <= mix_y;
               dout_valid <= 1'b1;
               level_q    <= '0;
               pair_q     <= '0;
            end else if (pair_q == last_pair) begin
               pair_q  <= '0;
               level_q <= level_q + 1'b1;
            end else begin
               pair_q <= pair_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Self-checking bench: directed literal mixes plus randomized traffic against a behavioural model.
module tb_voice_mix_sequencer;

   localparam int DB = 12;
   localparam int NV = 4;
   localparam int VW = NV * DB;
   localparam int MIDV = 2048;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_strobe = 1'b0;
   logic [VW-1:0] voices_in = '0;
   logic [NV-1:0] voice_mask = '0;
   logic [DB-1:0] dout;
   logic          dout_valid, busy, overrun;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model of the observable outputs after each edge.
   int m_dout = 0, m_valid = 0, m_busy = 0, m_ovr = 0;
   int m_rem = 0, m_pending = 0;

   voice_mix_sequencer #(.DATA_BITS(DB), .NUM_VOICES(NV), .LOG2_VOICES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_strobe (sample_strobe),
      .voices_in     (voices_in),
      .voice_mask    (voice_mask),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
      logic [VW-1:0] v;
      v[0*DB +: DB] = DB'(v0);
      v[1*DB +: DB] = DB'(v1);
      v[2*DB +: DB] = DB'(v2);
      v[3*DB +: DB] = DB'(v3);
      return v;
   endfunction

   // Halve the list repeatedly by averaging neighbours until one value is left.
   function automatic int mix_ref(input logic [VW-1:0] v, input logic [NV-1:0] m);
      int a[NV];
      for (int i = 0; i < NV; i++) a[i] = m[i] ? int'(v[i*DB +: DB]) : MIDV;
      for (int n = NV; n > 1; n = n / 2)
         for (int j = 0; j < n / 2; j++) a[j] = (a[2*j] + a[2*j+1]) / 2;
      return a[0];
   endfunction

   task automatic model_update(input logic r, input logic s, input logic [VW-1:0] v, input logic [NV-1:0] m);
      if (!r) begin
         m_dout = 0; m_valid = 0; m_busy = 0; m_ovr = 0; m_rem = 0;
      end else begin
         m_valid = 0;
         m_ovr   = 0;
         if (m_rem > 0) begin
            if (s) m_ovr = 1;
            m_rem--;
            if (m_rem == 0) begin
               m_dout  = m_pending;
               m_valid = 1;
            end
         end else if (s) begin
            m_pending = mix_ref(v, m);
            m_rem     = NV - 1;
         end
         m_busy = (m_rem > 0) ? 1 : 0;
      end
   endtask

   // Drive one cycle of inputs; returns at the following negedge with outputs settled.
   task automatic step(input logic r, input logic s, input logic [VW-1:0] v, input logic [NV-1:0] m);
      rst_n = r; sample_strobe = s; voices_in = v; voice_mask = m;
      @(posedge clk);
      #1 model_update(r, s, v, m);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, voices_in, voice_mask);
   endtask

   // Strobe once, idle until the result edge, then pin the output to a literal.
   task automatic mix_literal(input string name, input logic [VW-1:0] v, input logic [NV-1:0] m, input int exp);
      step(1'b1, 1'b1, v, m);
      check({name, "_busy"}, busy, 1);
      idle();
      idle();
      check({name, "_novalid_early"}, dout_valid, 0);
      idle();
      check({name, "_valid"}, dout_valid, 1);
      check({name, "_dout"}, dout, exp);
      check({name, "_busy_low"}, busy, 0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_dout", dout, m_dout);
         check("cyc_valid", dout_valid, m_valid);
         check("cyc_busy", busy, m_busy);
         check("cyc_overrun", overrun, m_ovr);
      end
   end

   initial begin
      @(negedge clk);
      step(1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, pack4(1, 2, 3, 4), 4'hF);
      chk_en = 1'b1;
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);

      mix_literal("basic", pack4(100, 200, 300, 400), 4'hF, 250);
      idle();
      check("basic_pulse_once", dout_valid, 0);
      check("basic_hold", dout, 250);

      mix_literal("trunc", pack4(1, 2, 4, 7), 4'hF, 3);
      mix_literal("full", pack4(4095, 4095, 4095, 4095), 4'hF, 4095);
      mix_literal("zero", pack4(0, 0, 0, 0), 4'hF, 0);
      mix_literal("mute1", pack4(0, 999, 3000, 17), 4'b0001, 1536);
      mix_literal("muteall", pack4(5, 6, 7, 8), 4'b0000, 2048);

      // Overrun: second strobe two cycles after the first.
      step(1'b1, 1'b1, pack4(100, 200, 300, 400), 4'hF);
      idle();
      step(1'b1, 1'b1, pack4(4095, 4095, 4095, 4095), 4'hF);
      check("ovr_pulse", overrun, 1);
      step(1'b1, 1'b0, pack4(0, 0, 0, 0), 4'h0);
      check("ovr_once", overrun, 0);
      check("ovr_valid", dout_valid, 1);
      check("ovr_dout", dout, 250);

      // Back-to-back: the second strobe lands in the valid cycle of the first.
      mix_literal("b2b_a", pack4(1, 2, 4, 7), 4'hF, 3);
      mix_literal("b2b_b", pack4(100, 200, 300, 400), 4'hF, 250);

      // Reset in the middle of a reduction.
      step(1'b1, 1'b1, pack4(4000, 4000, 4000, 4000), 4'hF);
      idle();
      step(1'b0, 1'b0, voices_in, voice_mask);
      check("midrst_dout", dout, 0);
      check("midrst_busy", busy, 0);
      for (int i = 0; i < 5; i++) begin
         idle();
         check("midrst_novalid", dout_valid, 0);
      end
      mix_literal("after_rst", pack4(100, 200, 300, 400), 4'hF, 250);

      for (int c = 0; c < 600; c++) begin
         logic [VW-1:0] v;
         for (int i = 0; i < NV; i++) begin
            case ($urandom_range(0, 3))
               0:       v[i*DB +: DB] = '0;
               1:       v[i*DB +: DB] = '1;
               default: v[i*DB +: DB] = DB'($urandom);
            endcase
         end
         step(($urandom_range(0, 80) != 0), ($urandom_range(0, 2) == 0), v, NV'($urandom));
      end

      idle();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
